// File: rtl/fp_pkg.sv
// Shared single-precision helpers for the FP datapath blocks: field widths,
// special encodings, field extraction and the divider FSM state type.
// No ports; imported by fp_divider_seq and fp_div_mant_step.
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_BIAS   = 127;

  localparam logic [7:0]  FP_EXP_INF = 8'hFF;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    SPEC
  } fp_div_state_t;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] fp_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fp_div_mant_step.sv
// One restoring radix-2 division step, purely combinational.
// Ports: rem_i (partial remainder), mb_i (divisor mantissa with hidden 1)
//        -> rem_next_o (remainder for the next step), q_bit_o (quotient bit).
module fp_div_mant_step
  import fp_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W
) (
  input  logic [MANT_W+1:0] rem_i,
  input  logic [MANT_W:0]   mb_i,
  output logic [MANT_W+1:0] rem_next_o,
  output logic              q_bit_o
);

  logic [MANT_W+1:0] diff;
  logic [MANT_W+1:0] kept;

  // Compare first, shift afterwards: the first step then weighs ma directly
  // against mb, so N steps yield floor(ma * 2^(N-1) / mb) and the remainder
  // (always < mb after the subtract) still fits after the shift.
  assign q_bit_o    = (rem_i >= {1'b0, mb_i});
  assign diff       = rem_i - {1'b0, mb_i};
  assign kept       = q_bit_o ? diff : rem_i;
  assign rem_next_o = kept << 1;

endmodule

// File: rtl/fp_divider_seq.sv
// Sequential single-precision divider, result = a / b, one quotient bit per clock.
// Ports: clk, rst_n (async, active-low); start/a/b request; busy while in flight;
//        done pulse with result and div_by_zero, both held until the next done.
module fp_divider_seq
  import fp_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int MANT_W = FP_MANT_W,
  parameter int BIAS   = FP_BIAS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero
);

  localparam int N_IT = MANT_W + 2;
  localparam logic signed [EXP_W+1:0] E_MAX = (EXP_W+2)'((1 << EXP_W) - 1);

  fp_div_state_t            state_q;
  logic [4:0]               cnt_q;
  logic                     sign_q;
  logic                     eb_zero_q;
  logic signed [EXP_W+1:0]  ed_q;
  logic [MANT_W:0]          mb_q;
  logic [MANT_W+1:0]        rem_q;
  logic [MANT_W+1:0]        q_q;
  logic                     done_q;
  logic [31:0]              result_q;
  logic                     dbz_q;

  logic [MANT_W+1:0]        rem_d;
  logic                     q_bit_d;
  logic signed [EXP_W+1:0]  e_norm;
  logic [MANT_W-1:0]        frac_norm;
  logic [31:0]              res_norm_d;

  fp_div_mant_step #(.MANT_W(MANT_W)) u_step (
    .rem_i      (rem_q),
    .mb_i       (mb_q),
    .rem_next_o (rem_d),
    .q_bit_o    (q_bit_d)
  );

  // Quotient lies in [2^(N_IT-2), 2^N_IT): its top bit decides whether the
  // leading one sits one place high (keep exponent) or not (exponent - 1).
  always_comb begin
    e_norm     = q_q[MANT_W+1] ? ed_q : ed_q - 1'b1;
    frac_norm  = q_q[MANT_W+1] ? q_q[MANT_W:1] : q_q[MANT_W-1:0];
    res_norm_d = {sign_q, e_norm[EXP_W-1:0], frac_norm};
    if (e_norm >= E_MAX) begin
      res_norm_d = {sign_q, FP_EXP_INF, {MANT_W{1'b0}}};
    end else if (e_norm <= 0) begin
      res_norm_d = {sign_q, {(EXP_W+MANT_W){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      eb_zero_q <= 1'b0;
      ed_q      <= '0;
      mb_q      <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse is held off one cycle.
          if (start && !done_q) begin
            sign_q    <= fp_sign(a) ^ fp_sign(b);
            eb_zero_q <= (fp_exp(b) == '0);
            ed_q      <= {2'b00, fp_exp(a)} - {2'b00, fp_exp(b)} + (EXP_W+2)'(BIAS);
            mb_q      <= {1'b1, fp_frac(b)};
            rem_q     <= {2'b01, fp_frac(a)};
            q_q       <= '0;
            cnt_q     <= '0;
            state_q   <= (fp_exp(a) == '0 || fp_exp(b) == '0) ? SPEC : DIV;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          q_q   <= {q_q[MANT_W:0], q_bit_d};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(N_IT - 1)) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          result_q <= res_norm_d;
          dbz_q    <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        SPEC: begin
          result_q <= eb_zero_q ? {sign_q, FP_EXP_INF, {MANT_W{1'b0}}}
                                : {sign_q, {(EXP_W+MANT_W){1'b0}}};
          dbz_q    <= eb_zero_q;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_divider_seq.sv
module tb_fp_divider_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  fp_divider_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dbz;
    int          lat;
    int          busy_cyc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   tests;
  int   fails;

  function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb,
                              input logic [31:0] vres, input logic vdbz);
    vec_t v;
    bit   spec;
    spec       = (va[30:23] == 8'h00) || (vb[30:23] == 8'h00);
    v.a        = va;
    v.b        = vb;
    v.res      = vres;
    v.dbz      = vdbz;
    v.lat      = spec ? 1 : 26;
    v.busy_cyc = spec ? 1 : 26;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Entered and left at #1 after a rising edge with the divider idle.
  task automatic run_op(input vec_t v, input int idx);
    int   cyc;
    int   bcnt;
    bit   seen;
    vec_t e;
    start = 1'b1;
    a     = v.a;
    b     = v.b;
    exp_q.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    bcnt  = busy ? 1 : 0;
    cyc   = 0;
    seen  = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) bcnt++;
      if (done) seen = 1;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL vec%0d timeout: no done within %0d cycles, expected at %0d", idx, cyc, e.lat);
    end else begin
      check($sformatf("vec%0d result", idx), result, e.res);
      check($sformatf("vec%0d div_by_zero", idx), {31'b0, div_by_zero}, {31'b0, e.dbz});
      check($sformatf("vec%0d latency", idx), cyc, e.lat);
      check($sformatf("vec%0d busy_cycles", idx), bcnt, e.busy_cyc);
      @(posedge clk); #1;
      check($sformatf("vec%0d done_pulse", idx), {31'b0, done}, 32'd0);
      check($sformatf("vec%0d result_held", idx), result, e.res);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int done_at;
    tests = 0;
    fails = 0;

    vecs.push_back(mk(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0)); // 6/2
    vecs.push_back(mk(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0)); // 1/3 truncated
    vecs.push_back(mk(32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1'b0)); // -6/2
    vecs.push_back(mk(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b0)); // -0/1
    vecs.push_back(mk(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1)); // 1/0
    vecs.push_back(mk(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0)); // clears flag
    vecs.push_back(mk(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0)); // overflow
    vecs.push_back(mk(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0)); // underflow
    vecs.push_back(mk(32'hBF80_0000, 32'hC040_0000, 32'h3EAA_AAAA, 1'b0)); // -1/-3
    vecs.push_back(mk(32'h0000_0000, 32'h8000_0000, 32'hFF80_0000, 1'b1)); // 0/-0: b checked first
    vecs.push_back(mk(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0)); // exp FF as normal
    vecs.push_back(mk(32'h3FC0_0000, 32'h3F80_0000, 32'h3FC0_0000, 1'b0)); // 1.5/1
    vecs.push_back(mk(32'h3F80_0000, 32'h3FC0_0000, 32'h3F2A_AAAA, 1'b0)); // 1/1.5
    vecs.push_back(mk(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 1'b0)); // e=1 kept
    vecs.push_back(mk(32'h0080_0000, 32'h3FC0_0000, 32'h0000_0000, 1'b0)); // e=0 flushed
    vecs.push_back(mk(32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 1'b0)); // e=254 kept
    vecs.push_back(mk(32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, 1'b0)); // e=255 -> inf

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset div_by_zero", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i], i);

    // Starts issued while busy must be dropped.
    start = 1'b1;
    a     = 32'h40C0_0000;
    b     = 32'h4000_0000;
    @(posedge clk); #1;
    start   = 1'b0;
    ndone   = 0;
    done_at = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        done_at = cyc;
        check("ignored_start result", result, 32'h4040_0000);
      end
      start = (cyc == 4 || cyc == 9);
      a     = 32'h3F80_0000;
      b     = 32'h0000_0000;
    end
    check("ignored_start done_count", ndone, 1);
    check("ignored_start done_at", done_at, 26);
    check("ignored_start idle_after", {31'b0, busy}, 32'd0);

    // Reset in the middle of an operation aborts it without a done.
    start = 1'b1;
    a     = 32'h3F80_0000;
    b     = 32'h4040_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("midop busy_before_reset", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midop reset busy", {31'b0, busy}, 32'd0);
    check("midop reset done", {31'b0, done}, 32'd0);
    check("midop reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midop no_done", ndone, 0);

    run_op(vecs[1], 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
